// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared store types, FSM states and offset helpers
// Used by store_merge_unit and store_lane_merge.
package riscv_mem_pkg;

  localparam int BYTE_W      = 8;
  localparam int DWORD_BYTES = 8;

  typedef enum logic [1:0] {
    ST_B = 2'b00,
    ST_H = 2'b01,
    ST_W = 2'b10,
    ST_D = 2'b11
  } store_type_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } sm_state_t;

  // Snap a byte offset down to the natural alignment of the access size.
  function automatic logic [2:0] natural_off(input store_type_t t, input logic [2:0] off);
    case (t)
      ST_B:    natural_off = off;
      ST_H:    natural_off = {off[2:1], 1'b0};
      ST_W:    natural_off = {off[2], 2'b00};
      default: natural_off = 3'b000;
    endcase
  endfunction

  function automatic logic is_misaligned(input store_type_t t, input logic [2:0] off);
    case (t)
      ST_B:    is_misaligned = 1'b0;
      ST_H:    is_misaligned = off[0];
      ST_W:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - combinational little-endian byte-lane merge of store data into a doubleword
module store_lane_merge
  import riscv_mem_pkg::*;
(
  input  logic [DWORD_BYTES*BYTE_W-1:0] i_rdata,
  input  logic [DWORD_BYTES*BYTE_W-1:0] i_store_data,
  input  logic [2:0]                    i_off,
  input  store_type_t                   i_store_type,
  output logic [DWORD_BYTES*BYTE_W-1:0] o_merged
);

  logic [3:0] w_nbytes;
  logic [2:0] w_rel;

  always_comb begin
    w_nbytes = 4'd1;
    w_rel    = 3'd0;
    o_merged = i_rdata;
    case (i_store_type)
      ST_B:    w_nbytes = 4'd1;
      ST_H:    w_nbytes = 4'd2;
      ST_W:    w_nbytes = 4'd4;
      default: w_nbytes = 4'd8;
    endcase
    // Lane b takes source byte (b - off) when it falls inside the access window.
    for (int b = 0; b < DWORD_BYTES; b++) begin
      w_rel = 3'(b) - i_off;
      if ((3'(b) >= i_off) && ({1'b0, w_rel} < w_nbytes)) begin
        o_merged[b*BYTE_W +: BYTE_W] = i_store_data[{w_rel, 3'b000} +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - read-modify-write store sequencer for a 64-bit memory without byte enables
// Optional misalignment trapping: STORE_MERGE_ALIGN_CHECK_EN.
module store_merge_unit
  import riscv_mem_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int XLEN       = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      store_type,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wr,
  output logic            busy,
  output logic            done,
  output logic            misaligned
);

  sm_state_t       r_state;
  store_type_t     r_type;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_rdata;
  logic [2:0]      r_cnt;
  logic [2:0]      w_off;
  logic [XLEN-1:0] w_merged;
  logic            w_mem_active;

`ifdef STORE_MERGE_ALIGN_CHECK_EN
  logic r_mis;

  // Misaligned requests never reach the merge, so the raw offset is safe here.
  assign w_off      = r_addr[2:0];
  assign misaligned = (r_state == DONE) && r_mis;
`else
  assign w_off      = natural_off(r_type, r_addr[2:0]);
  assign misaligned = 1'b0;
`endif

  store_lane_merge u_merge (
    .i_rdata      (r_rdata),
    .i_store_data (r_data),
    .i_off        (w_off),
    .i_store_type (r_type),
    .o_merged     (w_merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_type  <= ST_B;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_type <= store_type_t'(store_type);
            r_addr <= addr;
            r_data <= store_data;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
            if (is_misaligned(store_type_t'(store_type), addr[2:0])) begin
              r_mis   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= (store_type_t'(store_type) == ST_D) ? WR : RD;
            end
`else
            r_state <= (store_type_t'(store_type) == ST_D) ? WR : RD;
`endif
          end
        end
        RD: begin
          r_cnt   <= 3'(MEM_RD_LAT - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rdata <= mem_rdata;
            r_state <= WR;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        WR: r_state <= DONE;
        DONE: begin
`ifdef STORE_MERGE_ALIGN_CHECK_EN
          r_mis   <= 1'b0;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset drops mem_wr at once.
  assign w_mem_active = (r_state == RD) || (r_state == WAIT) || (r_state == WR);
  assign mem_addr     = w_mem_active ? {r_addr[XLEN-1:3], 3'b000} : '0;
  assign mem_wr       = (r_state == WR);
  assign mem_wdata    = (r_state == WR) ? w_merged : '0;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - directed bench for store_merge_unit at read latencies 1 and 3
module tb_store_merge_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic [1:0]  st;
  logic [63:0] ad, sdat;
  logic [63:0] rd_a, rd_b;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_wr, a_busy, a_done, a_mis;
  logic        b_wr, b_busy, b_done, b_mis;
  logic [63:0] pa, pb0, pb1, pb2;
  int checks = 0;
  int errors = 0;
  int wr_a = 0, done_a = 0, wr_b = 0, done_b = 0;
  int snap_w, snap_d;

  store_merge_unit #(.MEM_RD_LAT(1), .XLEN(64)) dut_a (
    .clock(clk), .reset(rst), .start(start_a), .store_type(st), .addr(ad), .store_data(sdat),
    .mem_rdata(rd_a), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wr(a_wr),
    .busy(a_busy), .done(a_done), .misaligned(a_mis)
  );

  store_merge_unit #(.MEM_RD_LAT(3), .XLEN(64)) dut_b (
    .clock(clk), .reset(rst), .start(start_b), .store_type(st), .addr(ad), .store_data(sdat),
    .mem_rdata(rd_b), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wr(b_wr),
    .busy(b_busy), .done(b_done), .misaligned(b_mis)
  );

  function automatic logic [63:0] rom(input logic [63:0] a);
    case (a)
      64'h1000: rom = 64'hFFFF_FFFF_FFFF_FFFF;
      64'h2000: rom = 64'h0123_4567_89AB_CDEF;
      64'h3000: rom = 64'h1111_2222_3333_4444;
      default:  rom = 64'hA5A5_A5A5_A5A5_A5A5;
    endcase
  endfunction

  // Memory read pipelines with the same latency each DUT is built for.
  always @(posedge clk) begin
    pa  <= rom(a_addr);
    pb0 <= rom(b_addr);
    pb1 <= pb0;
    pb2 <= pb1;
    if (a_wr)   wr_a   <= wr_a + 1;
    if (a_done) done_a <= done_a + 1;
    if (b_wr)   wr_b   <= wr_b + 1;
    if (b_done) done_b <= done_b + 1;
  end
  assign rd_a = pa;
  assign rd_b = pb2;

  task automatic issue(input bit to_b, input logic [1:0] t, input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    st = t; ad = a; sdat = d;
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; st = 2'b00; ad = '0; sdat = '0;
    repeat (3) @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %0b exp 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done_a got %0b exp 0", a_done); end
    checks++; if (a_wr !== 1'b0) begin errors++; $display("FAIL reset_wr_a got %0b exp 0", a_wr); end
    checks++; if (a_addr !== 64'h0) begin errors++; $display("FAIL reset_addr_a got %0h exp 0", a_addr); end
    checks++; if (a_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata_a got %0h exp 0", a_wdata); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL reset_mis_a got %0b exp 0", a_mis); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %0b exp 0", b_busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sd;
    issue(1'b0, 2'b11, 64'h1000, 64'h1122_3344_5566_7788);
    @(negedge clk);
    checks++; if (a_wr !== 1'b1) begin errors++; $display("FAIL sd_wr_t1 got %0b exp 1", a_wr); end
    checks++; if (a_addr !== 64'h1000) begin errors++; $display("FAIL sd_addr got %0h exp 1000", a_addr); end
    checks++; if (a_wdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL sd_wdata got %0h exp 1122334455667788", a_wdata); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL sd_done_t2 got %0b exp 1", a_done); end
    checks++; if (a_wr !== 1'b0) begin errors++; $display("FAIL sd_wr_t2 got %0b exp 0", a_wr); end
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL sd_idle_t3 got %0b exp 0", a_busy); end
  endtask

  task automatic test_sb_lat1;
    issue(1'b0, 2'b00, 64'h1005, 64'hCDCD_CDCD_CDCD_CDAB);
    @(negedge clk);
    checks++; if (a_addr !== 64'h1000 || a_wr !== 1'b0) begin errors++; $display("FAIL sb_rd_t1 got addr %0h wr %0b exp 1000 0", a_addr, a_wr); end
    @(negedge clk);
    checks++; if (a_wr !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL sb_wait_t2 got wr %0b busy %0b exp 0 1", a_wr, a_busy); end
    @(negedge clk);
    checks++; if (a_wr !== 1'b1) begin errors++; $display("FAIL sb_wr_t3 got %0b exp 1", a_wr); end
    checks++; if (a_wdata !== 64'hFFFF_ABFF_FFFF_FFFF) begin errors++; $display("FAIL sb_wdata got %0h exp ffffabffffffffff", a_wdata); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL sb_done_t4 got %0b exp 1", a_done); end
    @(negedge clk);
  endtask

  task automatic test_sw_lat3;
    issue(1'b1, 2'b10, 64'h2004, 64'h5555_5555_DEAD_BEEF);
    repeat (4) @(negedge clk);
    checks++; if (b_wr !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL sw_wait_t4 got wr %0b busy %0b exp 0 1", b_wr, b_busy); end
    @(negedge clk);
    checks++; if (b_wr !== 1'b1 || b_addr !== 64'h2000) begin errors++; $display("FAIL sw_wr_t5 got wr %0b addr %0h exp 1 2000", b_wr, b_addr); end
    checks++; if (b_wdata !== 64'hDEAD_BEEF_89AB_CDEF) begin errors++; $display("FAIL sw_wdata got %0h exp deadbeef89abcdef", b_wdata); end
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL sw_done_t6 got %0b exp 1", b_done); end
    @(negedge clk);
  endtask

  task automatic test_sh_misaligned;
    snap_w = wr_a;
    issue(1'b0, 2'b01, 64'h3003, 64'h1234_5678_9ABC_BEEF);
    @(negedge clk);
`ifdef STORE_MERGE_ALIGN_CHECK_EN
    checks++; if (a_done !== 1'b1 || a_mis !== 1'b1) begin errors++; $display("FAIL shmis_t1 got done %0b mis %0b exp 1 1", a_done, a_mis); end
    repeat (3) @(negedge clk);
    checks++; if (wr_a != snap_w) begin errors++; $display("FAIL shmis_nowrite got %0d writes exp 0", wr_a - snap_w); end
`else
    checks++; if (a_addr !== 64'h3000 || a_wr !== 1'b0) begin errors++; $display("FAIL sh_rd_t1 got addr %0h wr %0b exp 3000 0", a_addr, a_wr); end
    repeat (2) @(negedge clk);
    checks++; if (a_wr !== 1'b1 || a_wdata !== 64'h1111_2222_BEEF_4444) begin errors++; $display("FAIL sh_wr_t3 got wr %0b wdata %0h exp 1 11112222beef4444", a_wr, a_wdata); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_mis !== 1'b0) begin errors++; $display("FAIL sh_done_t4 got done %0b mis %0b exp 1 0", a_done, a_mis); end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid;
    snap_w = wr_a;
    issue(1'b0, 2'b00, 64'h1005, 64'h0000_0000_0000_0011);
    repeat (2) @(negedge clk);
    checks++; if (a_busy !== 1'b1 || a_wr !== 1'b0) begin errors++; $display("FAIL rmid_wait got busy %0b wr %0b exp 1 0", a_busy, a_wr); end
    rst = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b0 || a_wr !== 1'b0 || a_addr !== 64'h0) begin errors++; $display("FAIL rmid_async got busy %0b wr %0b addr %0h exp 0 0 0", a_busy, a_wr, a_addr); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wr_a != snap_w) begin errors++; $display("FAIL rmid_nowrite got %0d writes exp 0", wr_a - snap_w); end
    issue(1'b0, 2'b11, 64'h1000, 64'h0F0E_0D0C_0B0A_0908);
    @(negedge clk);
    checks++; if (a_wr !== 1'b1 || a_wdata !== 64'h0F0E_0D0C_0B0A_0908) begin errors++; $display("FAIL rmid_sd_wr got wr %0b wdata %0h exp 1 0f0e0d0c0b0a0908", a_wr, a_wdata); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL rmid_sd_done got %0b exp 1", a_done); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    snap_w = wr_b;
    snap_d = done_b;
    issue(1'b1, 2'b00, 64'h2002, 64'h9999_9999_9999_9977);
    @(negedge clk);
    @(negedge clk);
    start_b = 1'b1; st = 2'b11; ad = 64'h1000; sdat = '1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b_wr !== 1'b1 || b_wdata !== 64'h0123_4567_8977_CDEF) begin errors++; $display("FAIL b2b_wr_t5 got wr %0b wdata %0h exp 1 012345678977cdef", b_wr, b_wdata); end
    @(negedge clk);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL b2b_done_t6 got %0b exp 1", b_done); end
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored got busy %0b exp 0", b_busy); end
    repeat (4) @(negedge clk);
    checks++; if (wr_b - snap_w != 1) begin errors++; $display("FAIL b2b_write_count got %0d exp 1", wr_b - snap_w); end
    checks++; if (done_b - snap_d != 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", done_b - snap_d); end
  endtask

  initial begin
    test_reset;
    test_sd;
    test_sb_lat1;
    test_sw_lat3;
    test_sh_misaligned;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
